// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the 5-stage WISC pipeline: tracks per-stage valid
// bits and resolves load-use, mispredict, memory-wait and HLT-drain conditions.
module pipeline_hazard_ctrl #(
    parameter int MAX_MEM_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_src1,
    input  logic [3:0] id_src2,
    input  logic       id_uses_src1,
    input  logic       id_uses_src2,
    input  logic       id_halt,
    input  logic [3:0] ex_dst,
    input  logic       ex_mem_read,
    input  logic       ex_mispredict,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       if_id_we,
    output logic       if_id_flush,
    output logic       id_ex_we,
    output logic       id_ex_flush,
    output logic       ex_mem_we,
    output logic       mem_wb_we,
    output logic       stall,
    output logic [4:0] stage_valid,
    output logic [1:0] ctrl_state,
    output logic       halted,
    output logic       mem_timeout
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_MEM_WAIT);

    localparam int V_IF  = 0;
    localparam int V_ID  = 1;
    localparam int V_EX  = 2;
    localparam int V_MEM = 3;
    localparam int V_WB  = 4;

    logic [4:0] valid_reg, valid_next;
    logic [1:0] state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       timeout_reg, timeout_next;

    logic [4:0] valid_shift;
    logic       in_run, in_drain, in_halted;
    logic       src1_hit, src2_hit;
    logic       mem_stall, load_use, mispredict, halt_enter;

    // Encoding 3 is unreachable; decoding bit 1 parks it in HALTED until reset.
    assign in_halted = state_reg[1];
    assign in_drain  = (state_reg == ST_DRAIN);
    assign in_run    = (state_reg == ST_RUN);

    // Plain advance toward WB; a new fetch enters IF only while running.
    assign valid_shift[V_IF] = in_run;
    genvar gi;
    generate
        for (gi = 1; gi < 5; gi++) begin : g_shift
            assign valid_shift[gi] = valid_reg[gi-1];
        end
    endgenerate

    assign src1_hit = id_uses_src1 && (id_src1 == ex_dst);
    assign src2_hit = id_uses_src2 && (id_src2 == ex_dst);

    assign mem_stall  = valid_reg[V_MEM] && mem_req && !mem_ready;
    assign load_use   = in_run && valid_reg[V_EX] && valid_reg[V_ID] && ex_mem_read
                        && (ex_dst != 4'd0) && (src1_hit || src2_hit);
    assign mispredict = in_run && valid_reg[V_EX] && ex_mispredict;
    assign halt_enter = in_run && id_halt && valid_reg[V_ID] && !mem_stall && !mispredict;

    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_we    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        stall       = 1'b0;
        valid_next  = valid_reg;
        state_next  = state_reg;

        if (in_halted) begin
            valid_next = 5'b00000;
        end else if (mem_stall) begin
            // Freeze everything up to MEM; WB receives a bubble.
            mem_wb_we        = 1'b1;
            stall            = 1'b1;
            valid_next[V_WB] = 1'b0;
        end else if (in_drain) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            valid_next  = valid_shift;
            if (valid_reg[V_WB:V_EX] == 3'b000)
                state_next = ST_HALTED;
        end else if (mispredict) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            valid_next  = {valid_reg[V_MEM], valid_reg[V_EX], 3'b001};
        end else if (halt_enter) begin
            // HLT is squashed on entry so it never reaches EX.
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            valid_next  = {valid_reg[V_MEM], valid_reg[V_EX], 3'b000};
            state_next  = ST_DRAIN;
        end else if (load_use) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            stall       = 1'b1;
            valid_next  = {valid_reg[V_MEM], valid_reg[V_EX], 1'b0, valid_reg[V_ID:V_IF]};
        end else begin
            pc_we      = 1'b1;
            if_id_we   = 1'b1;
            id_ex_we   = 1'b1;
            ex_mem_we  = 1'b1;
            mem_wb_we  = 1'b1;
            valid_next = valid_shift;
        end
    end

    always_comb begin
        wait_cnt_next = 8'd0;
        timeout_next  = timeout_reg;
        if (mem_stall) begin
            wait_cnt_next = (wait_cnt_reg == WAIT_LIMIT) ? wait_cnt_reg : wait_cnt_reg + 8'd1;
            if (wait_cnt_reg >= WAIT_LIMIT - 8'd1)
                timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 5'b00001;
            state_reg    <= ST_RUN;
            wait_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
        end else begin
            valid_reg    <= valid_next;
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign stage_valid = valid_reg;
    assign ctrl_state  = state_reg;
    assign halted      = in_halted;
    assign mem_timeout = timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus a randomized run checked against a stage-level
// reference model of the hazard controller.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, ex_dst;
    logic       id_uses_src1, id_uses_src2, id_halt;
    logic       ex_mem_read, ex_mispredict, mem_req, mem_ready;
    logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic       ex_mem_we, mem_wb_we, stall, halted, mem_timeout;
    logic [4:0] stage_valid;
    logic [1:0] ctrl_state;

    int checks = 0;
    int errors = 0;

    logic [4:0]  we_vec;
    logic [1:0]  flush_vec;
    logic [16:0] dut_vec;
    assign we_vec    = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we};
    assign flush_vec = {if_id_flush, id_ex_flush};
    assign dut_vec   = {we_vec, flush_vec, stall, stage_valid, ctrl_state, halted, mem_timeout};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MAX_MEM_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .id_halt(id_halt), .ex_dst(ex_dst),
        .ex_mem_read(ex_mem_read), .ex_mispredict(ex_mispredict),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .stall(stall),
        .stage_valid(stage_valid), .ctrl_state(ctrl_state),
        .halted(halted), .mem_timeout(mem_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; ex_dst = 4'd0;
        id_uses_src1 = 1'b0; id_uses_src2 = 1'b0; id_halt = 1'b0;
        ex_mem_read = 1'b0; ex_mispredict = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        #1;
        checks++;
        if (stage_valid !== 5'b00001 || ctrl_state !== 2'd0 || halted !== 1'b0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b st=%0d halted=%b to=%b, expected v=00001 st=0 halted=0 to=0",
                     stage_valid, ctrl_state, halted, mem_timeout);
        end
    endtask

    task automatic test_idle_fill();
        logic [4:0] exp_v [6];
        exp_v = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111};
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (stage_valid !== exp_v[i] || we_vec !== 5'b11111 || stall !== 1'b0) begin
                errors++;
                $display("FAIL idle_fill[%0d]: got v=%b we=%b stall=%b, expected v=%b we=11111 stall=0",
                         i, stage_valid, we_vec, stall, exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_dst = 4'd3; id_src1 = 4'd3; id_uses_src1 = 1'b1;
        #1;
        checks++;
        if (we_vec !== 5'b00111 || id_ex_flush !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use: got we=%b id_ex_flush=%b stall=%b, expected we=00111 id_ex_flush=1 stall=1",
                     we_vec, id_ex_flush, stall);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stage_valid !== 5'b11011) begin
            errors++;
            $display("FAIL load_use_bubble: got v=%b expected 11011", stage_valid);
        end
        tick();
        ex_mem_read = 1'b1; ex_dst = 4'd0; id_src1 = 4'd0; id_uses_src1 = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || we_vec !== 5'b11111) begin
            errors++;
            $display("FAIL load_use_r0: got stall=%b we=%b, expected stall=0 we=11111", stall, we_vec);
        end
        tick();
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_mem_wait();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (we_vec !== 5'b00001 || stall !== 1'b1) begin
                errors++;
                $display("FAIL mem_freeze[%0d]: got we=%b stall=%b, expected we=00001 stall=1", k, we_vec, stall);
            end
            tick();
            checks++;
            if (stage_valid !== 5'b01111) begin
                errors++;
                $display("FAIL mem_freeze_valid[%0d]: got v=%b expected 01111", k, stage_valid);
            end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || we_vec !== 5'b11111 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mem_release: got stall=%b we=%b to=%b, expected stall=0 we=11111 to=0",
                     stall, we_vec, mem_timeout);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mispredict_load_use();
        ex_mispredict = 1'b1;
        ex_mem_read = 1'b1; ex_dst = 4'd5; id_src2 = 4'd5; id_uses_src2 = 1'b1;
        #1;
        checks++;
        if (flush_vec !== 2'b11 || pc_we !== 1'b1 || stall !== 1'b0 || we_vec !== 5'b11111) begin
            errors++;
            $display("FAIL mispredict_lu: got flush=%b we=%b stall=%b, expected flush=11 we=11111 stall=0",
                     flush_vec, we_vec, stall);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stage_valid !== 5'b11001) begin
            errors++;
            $display("FAIL mispredict_valid: got v=%b expected 11001", stage_valid);
        end
    endtask

    task automatic test_halt_drain();
        for (int i = 0; i < 4; i++) tick();
        id_halt = 1'b1; ex_mispredict = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctrl_state !== 2'd0 || stage_valid !== 5'b11001) begin
            errors++;
            $display("FAIL halt_vs_mispredict: got st=%0d v=%b, expected st=0 v=11001", ctrl_state, stage_valid);
        end
        for (int i = 0; i < 4; i++) tick();
        id_halt = 1'b1;
        #1;
        checks++;
        if (pc_we !== 1'b0 || flush_vec !== 2'b11) begin
            errors++;
            $display("FAIL halt_enter: got pc_we=%b flush=%b, expected pc_we=0 flush=11", pc_we, flush_vec);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctrl_state !== 2'd1 || stage_valid !== 5'b11000 || pc_we !== 1'b0 || if_id_we !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry: got st=%0d v=%b pc_we=%b if_id_we=%b, expected st=1 v=11000 pc_we=0 if_id_we=0",
                     ctrl_state, stage_valid, pc_we, if_id_we);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (halted !== (i == 3) || pc_we !== 1'b0) begin
                errors++;
                $display("FAIL drain_count[%0d]: got halted=%b pc_we=%b, expected halted=%b pc_we=0",
                         i, halted, pc_we, (i == 3));
            end
        end
        checks++;
        if (ctrl_state !== 2'd2 || stage_valid !== 5'b00000 || we_vec !== 5'b00000 || flush_vec !== 2'b00) begin
            errors++;
            $display("FAIL halted_outputs: got st=%0d v=%b we=%b flush=%b, expected st=2 v=00000 we=00000 flush=00",
                     ctrl_state, stage_valid, we_vec, flush_vec);
        end
        tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halted_hold: got halted=%b expected 1", halted);
        end
        do_reset();
        #1;
        checks++;
        if (ctrl_state !== 2'd0 || stage_valid !== 5'b00001) begin
            errors++;
            $display("FAIL halt_reset: got st=%0d v=%b, expected st=0 v=00001", ctrl_state, stage_valid);
        end
    endtask

    task automatic test_timeout();
        idle_inputs();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (mem_timeout !== (k >= MAX_WAIT)) begin
                errors++;
                $display("FAIL timeout_rise[%0d]: got to=%b expected %b", k, mem_timeout, (k >= MAX_WAIT));
            end
        end
        mem_ready = 1'b1;
        tick();
        checks++;
        if (mem_timeout !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: got to=%b stall=%b expected to=1 stall=0", mem_timeout, stall);
        end
        idle_inputs();
        do_reset();
        #1;
        checks++;
        if (mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_reset: got to=%b expected 0", mem_timeout);
        end
    endtask

    // Reference model: per-stage valid flags, a mode (0 run, 1 drain, 2 halted),
    // a stall-cycle count and a sticky timeout flag.
    bit mv [5];
    bit nmv [5];
    int mmode, nmode, mcnt, ncnt;
    bit mto, nto;

    task automatic model_reset();
        mv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        mmode = 0; mcnt = 0; mto = 1'b0;
    endtask

    task automatic model_eval(output logic [16:0] ev);
        bit ms, lu, mp, hz;
        bit [4:0] we;
        bit [1:0] fl;
        bit st;
        logic [4:0] vv;
        we = '0; fl = '0; st = 1'b0;
        nmv = mv; nmode = mmode; ncnt = 0; nto = mto;
        ms = (mmode != 2) && mv[3] && mem_req && !mem_ready;
        lu = (mmode == 0) && mv[2] && mv[1] && ex_mem_read && (ex_dst != 0)
             && ((id_uses_src1 && id_src1 == ex_dst) || (id_uses_src2 && id_src2 == ex_dst));
        mp = (mmode == 0) && mv[2] && ex_mispredict;
        hz = (mmode == 0) && id_halt && mv[1] && !ms && !mp;
        if (mmode == 2) begin
        end else if (ms) begin
            we = 5'b00001; st = 1'b1; nmv[4] = 1'b0;
        end else if (mmode == 1) begin
            we = 5'b00111; fl = 2'b01;
            for (int s = 4; s >= 1; s--) nmv[s] = mv[s-1];
            nmv[0] = 1'b0;
            if (!mv[2] && !mv[3] && !mv[4]) nmode = 2;
        end else if (mp) begin
            we = 5'b11111; fl = 2'b11;
            nmv[4] = mv[3]; nmv[3] = mv[2]; nmv[2] = 1'b0; nmv[1] = 1'b0; nmv[0] = 1'b1;
        end else if (hz) begin
            we = 5'b01111; fl = 2'b11;
            nmv[4] = mv[3]; nmv[3] = mv[2]; nmv[2] = 1'b0; nmv[1] = 1'b0; nmv[0] = 1'b0;
            nmode = 1;
        end else if (lu) begin
            we = 5'b00111; fl = 2'b01; st = 1'b1;
            nmv[4] = mv[3]; nmv[3] = mv[2]; nmv[2] = 1'b0;
        end else begin
            we = 5'b11111;
            for (int s = 4; s >= 1; s--) nmv[s] = mv[s-1];
            nmv[0] = 1'b1;
        end
        if (ms) begin
            ncnt = (mcnt < MAX_WAIT) ? mcnt + 1 : mcnt;
            if (mcnt + 1 >= MAX_WAIT) nto = 1'b1;
        end
        vv = {mv[4], mv[3], mv[2], mv[1], mv[0]};
        ev = {we, fl, st, vv, 2'(mmode), (mmode == 2), mto};
    endtask

    task automatic test_random();
        logic [16:0] ev;
        idle_inputs();
        do_reset();
        model_reset();
        for (int n = 0; n < 800; n++) begin
            id_src1       = 4'($urandom_range(0, 3));
            id_src2       = 4'($urandom_range(0, 3));
            ex_dst        = 4'($urandom_range(0, 3));
            id_uses_src1  = ($urandom_range(0, 1) == 1);
            id_uses_src2  = ($urandom_range(0, 1) == 1);
            ex_mem_read   = ($urandom_range(0, 99) < 35);
            ex_mispredict = ($urandom_range(0, 99) < 10);
            id_halt       = ($urandom_range(0, 99) < 3);
            mem_req       = ($urandom_range(0, 99) < 40);
            mem_ready     = ($urandom_range(0, 99) < 55);
            rst           = ($urandom_range(0, 99) < 3);
            #1;
            model_eval(ev);
            checks++;
            if (dut_vec !== ev) begin
                errors++;
                $display("FAIL random[%0d]: got we/fl/stall/v/st/h/to=%b expected %b", n, dut_vec, ev);
            end
            tick();
            if (rst) begin
                model_reset();
            end else begin
                mv = nmv; mmode = nmode; mcnt = ncnt; mto = nto;
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_idle_fill();
        test_load_use();
        test_mem_wait();
        test_mispredict_load_use();
        test_halt_drain();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage WISC pipeline (IF, ID, EX, MEM, WB).
- Tracks a valid bit per stage and drives the PC and pipeline-register write enables and flushes.
- Resolves four conditions: load-use hazards, EX-resolved branch mispredicts, multi-cycle data-memory handshakes, and HLT drain.
- Sits beside the datapath. Its stall output feeds the pipeline trace monitor.

Parameters:
MAX_MEM_WAIT, 15, consecutive memory-stall cycles tolerated before mem_timeout is raised (1..255).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
id_src1  input  4  ID-stage source register 1.
id_src2  input  4  ID-stage source register 2.
id_uses_src1  input  1  ID instruction reads src1.
id_uses_src2  input  1  ID instruction reads src2.
id_halt  input  1  ID instruction is HLT.
ex_dst  input  4  EX-stage destination register.
ex_mem_read  input  1  EX instruction is a load.
ex_mispredict  input  1  EX branch resolved opposite to prediction.
mem_req  input  1  MEM instruction accesses data memory.
mem_ready  input  1  data memory completes the access this cycle.
pc_we  output  1  PC update enable.
if_id_we  output  1  IF/ID register write enable.
if_id_flush  output  1  IF/ID register bubble.
id_ex_we  output  1  ID/EX register write enable.
id_ex_flush  output  1  ID/EX register bubble.
ex_mem_we  output  1  EX/MEM register write enable.
mem_wb_we  output  1  MEM/WB register write enable.
stall  output  1  any freeze or load-use stall this cycle.
stage_valid  output  5  valid bits: [0]=IF, [1]=ID, [2]=EX, [3]=MEM, [4]=WB.
ctrl_state  output  2  0=RUN, 1=DRAIN, 2=HALTED.
halted  output  1  high in HALTED.
mem_timeout  output  1  sticky memory-timeout flag.

Behaviour:
Reset (next posedge with rst=1):
- stage_valid=5'b00001, ctrl_state=RUN, wait counter=0, mem_timeout=0.
- Enable and flush outputs are combinational from state and inputs.

Condition terms (all combinational):
- mem_stall = v[MEM] & mem_req & !mem_ready.
- load_use = v[EX] & v[ID] & ex_mem_read & (ex_dst != 0) & ((id_uses_src1 & id_src1 == ex_dst) | (id_uses_src2 & id_src2 == ex_dst)).
- mispredict = v[EX] & ex_mispredict.

Priority, highest first:
1. HALTED
   - All WE=0, flushes=0, stage_valid=0.
   - Held until rst.
2. mem_stall (freeze)
   - pc_we, if_id_we, id_ex_we, ex_mem_we = 0; mem_wb_we=1.
   - v[WB]<=0 (bubble); other v held; stall=1.
3. mispredict
   - All WE=1, if_id_flush=1, id_ex_flush=1, PC redirects.
   - v[ID]<=0, v[EX]<=0, v[IF]<=1; remaining v shift.
   - Overrides load_use and id_halt in the same cycle, since ID is wrong-path.
4. load_use
   - pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1, mem_wb_we=1, stall=1.
   - v[EX]<=0; IF/ID held; MEM/WB shift.
5. Normal
   - All WE=1, v shifts toward WB, v[IF]<=1 in RUN.

State machine:
- RUN -> DRAIN: when id_halt & v[ID] and neither mem_stall nor mispredict is active.
  - On the entering cycle: pc_we=0, if_id_flush=1, id_ex_flush=1.
  - The HLT is squashed and has no side effects. v[IF], v[ID] <= 0.
- DRAIN:
  - pc_we=0, if_id_we=0, v[IF], v[ID] stay 0.
  - EX/MEM/WB advance under mem_stall rules.
  - load_use and mispredict are impossible (ID empty); ignore them.
- DRAIN -> HALTED: when v[EX], v[MEM], v[WB] are all 0 at a posedge.

Memory timeout:
- The wait counter increments each mem_stall cycle and clears on any non-mem_stall cycle.
- When the counter reaches MAX_MEM_WAIT, mem_timeout<=1 (sticky until rst) and the counter saturates.
- The freeze continues; the controller does not recover on its own.

Other rules:
- ex_dst==0 never causes load_use (r0 is hardwired).
- rst mid-DRAIN, mid-freeze, or while HALTED returns to the reset values on the next posedge.

Test Plan:
1. Reset then 6 idle cycles, no hazards -> stage_valid 00001, 00011, 00111, 01111, 11111, 11111; all WE=1; stall=0.
2. Load-use: ex_mem_read=1, ex_dst=3, id_src1=3, id_uses_src1=1 for one cycle -> pc_we=0, if_id_we=0, id_ex_flush=1, stall=1; next cycle v[EX]=0. Repeat with ex_dst=0 -> no stall.
3. Mem wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 freeze cycles (ex_mem_we=0, stall=1, v[WB]=0 after the first); normal operation on cycle 4; mem_timeout=0.
4. Mispredict and load_use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_we=1, stall=0; next cycle v[ID]=0, v[EX]=0.
5. HLT in ID with a full pipe -> ctrl_state=DRAIN; pc_we stays 0; halted=1 exactly 3 cycles later; id_halt coincident with mispredict -> stays RUN.
6. MAX_MEM_WAIT=4, mem_ready held 0 -> mem_timeout rises after the 4th stall cycle and stays 1 after mem_ready=1; rst clears it.
